// File: rtl/chunked_serial_adder_if.sv
// Valid/ready operand and result bundle for chunked_serial_adder.
// master = producer/consumer side, slave = the adder.
interface chunked_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through a ripple of full-adder cells,
// with a registered carry between chunks. Result is held until the consumer accepts it.
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    chunked_serial_adder_if.slave bus
);
    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c, c_out, c_msb_in;
    logic [31:0]      base;

    assign in_ready      = rst_n & (state_q == StIdle);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // One CHUNK-bit ripple of full-adder cells over the chunk selected by idx_q.
    always_comb begin
        base     = 32'(idx_q) * CHUNK;
        a_chunk  = a_q[base +: CHUNK];
        b_chunk  = b_q[base +: CHUNK];
        s_chunk  = '0;
        c        = carry_q;
        c_msb_in = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) c_msb_in = c;
            s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c;
            c          = (a_chunk[i] & b_chunk[i]) | (c & (a_chunk[i] ^ b_chunk[i]));
        end
        c_out = c;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[base +: CHUNK] = s_chunk;
                carry_d              = c_out;
                if (idx_q == LastIdx) begin
                    cout_d      = c_out;
                    ovf_d       = c_msb_in ^ c_out;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: 16/4 datapath vectors, backpressure, reset abort,
// and exhaustive 4-bit sweeps at CHUNK=1 and CHUNK=4.
module tb_chunked_serial_adder;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    chunked_serial_adder_if #(.WIDTH(16)) bus  ();
    chunked_serial_adder_if #(.WIDTH(4))  bus1 ();
    chunked_serial_adder_if #(.WIDTH(4))  bus4 ();

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    chunked_serial_adder #(.WIDTH(4),  .CHUNK(1)) u_dut_c1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    chunked_serial_adder #(.WIDTH(4),  .CHUNK(4)) u_dut_c4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub);
        check_eq("in_ready_pre", 32'(bus.in_ready), 1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] es, input logic ec,
                               input logic eo);
        int lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 4);
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, "_ov_drop"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_rdy_back"}, 32'(bus.in_ready), 1);
    endtask

    // Independent 4-bit model; ovf from operand/result sign relation.
    task automatic sweep_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input logic sub);
        logic [3:0] bb;
        logic       c0, eovf;
        logic [4:0] full;
        logic [5:0] exp;
        int         lat, l1, l4;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {4'b0, c0};
        eovf = (a[3] == bb[3]) && (full[3] != a[3]);
        exp  = {full[4], eovf, full[3:0]};
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
        bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        lat = 0; l1 = -1; l4 = -1;
        while (lat < 20) begin
            if (bus1.out_valid && l1 < 0) l1 = lat;
            if (bus4.out_valid && l4 < 0) l4 = lat;
            if (l1 >= 0 && l4 >= 0) break;
            @(negedge clk);
            lat++;
        end
        check_eq("sw_c1_lat", l1, 4);
        check_eq("sw_c4_lat", l4, 1);
        check_eq("sw_c1_res", 32'({bus1.cout, bus1.ovf, bus1.sum}), 32'(exp));
        check_eq("sw_c4_res", 32'({bus4.cout, bus4.ovf, bus4.sum}), 32'(exp));
        bus1.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0; bus.out_ready  = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_sum", 32'(bus.sum), 0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 32'(bus.in_ready), 1);

        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("t1", 16'h5555, 1'b0, 1'b0);
        drain("t1");
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("t2a", 16'h0000, 1'b1, 1'b0);
        drain("t2a");
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_result("t2b", 16'h0000, 1'b1, 1'b0);
        drain("t2b");
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result("t3a", 16'h8000, 1'b0, 1'b1);
        drain("t3a");
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result("t3b", 16'hFFFE, 1'b0, 1'b0);
        drain("t3b");

        // Backpressure with a new request held on the input.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("bp0", 16'h5555, 1'b0, 1'b0);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_sum", 32'(bus.sum), 32'h5555);
            check_eq("bp_ov", 32'(bus.out_valid), 1);
            check_eq("bp_rdy", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("bp_ov_drop", 32'(bus.out_valid), 0);
        check_eq("bp_rdy_back", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("bp_taken", 32'(bus.in_ready), 0);
        wait_result("bp1", 16'h3333, 1'b0, 1'b0);
        drain("bp1");

        // Reset while chunk k=2 is next to be processed.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ov", 32'(bus.out_valid), 0);
        check_eq("mid_rst_res", 32'({bus.cout, bus.ovf, bus.sum}), 0);
        check_eq("mid_rst_rdy", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_result("t5", 16'h0100, 1'b0, 1'b0);
        drain("t5");

        for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        sweep_op(4'(x), 4'(y), 1'(ci), 1'(s));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
